axi_lite_regfile: RTL and testbench

- Parametrised AXI4-Lite slave register file; successor to the single-mode/add-value control block.
- Provides NUM_REGS read/write control registers and NUM_STATUS read-only status words.
- Implements full AW/W/B and AR/R handshakes with backpressure, byte strobes, OKAY/SLVERR responses, and per-register write pulses.
- Sits between the host AXI-Lite interconnect and the stream datapath. Register 0 carries the datapath mode.

---
 rtl/axi_lite_regfile_if.sv | 38 +++
 rtl/axi_lite_regfile.sv | 216 +++++++++++++++++++++
 tb/tb_axi_lite_regfile.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_regfile_if.sv
// AXI4-Lite slave-side bundle for the register file: AW/W/B write channels and AR/R read channels.
// Valid/ready: a beat moves on a rising edge where both are high; a raised valid holds its payload until that edge.
interface axi_lite_regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) ();
  logic                      s_axi_awvalid;
  logic                      s_axi_awready;
  logic [ADDR_WIDTH-1:0]     s_axi_awaddr;
  logic                      s_axi_wvalid;
  logic                      s_axi_wready;
  logic [DATA_WIDTH-1:0]     s_axi_wdata;
  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb;
  logic                      s_axi_bvalid;
  logic                      s_axi_bready;
  logic [1:0]                s_axi_bresp;
  logic                      s_axi_arvalid;
  logic                      s_axi_arready;
  logic [ADDR_WIDTH-1:0]     s_axi_araddr;
  logic                      s_axi_rvalid;
  logic                      s_axi_rready;
  logic [DATA_WIDTH-1:0]     s_axi_rdata;
  logic [1:0]                s_axi_rresp;

  modport slave (
    input  s_axi_awvalid, s_axi_awaddr, s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
    input  s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
    output s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp
  );

  modport master (
    output s_axi_awvalid, s_axi_awaddr, s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
    output s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
    input  s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp
  );
endinterface

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite register file: NUM_REGS byte-strobed control registers, NUM_STATUS read-only status words.
// Independent write (IDLE/COMMIT/RESP) and read (IDLE/DATA) FSMs; every AXI output comes straight from a flop.
module axi_lite_regfile #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    NUM_REGS   = 8,
  parameter int                    NUM_STATUS = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                                                   s_axi_aclk,
  input  logic                                                   s_axi_areset,
  axi_lite_regfile_if.slave                                      s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0]                         ctrl_regs,
  output logic [NUM_REGS-1:0]                                    wr_pulse,
  // Kept at least one word wide so a build without status words still has a legal port.
  input  logic [(NUM_STATUS > 0 ? NUM_STATUS : 1)*DATA_WIDTH-1:0] status_in,
  output logic [1:0]                                             dbg_wr_state_o,
  output logic                                                   dbg_rd_state_o
);

  localparam int          STRB_W = DATA_WIDTH / 8;
  localparam int          IDX_W  = ADDR_WIDTH - 2;
  localparam logic [31:0] NREG_U = NUM_REGS;
  localparam logic [31:0] NEND_U = NUM_REGS + NUM_STATUS;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wr_state_e;
  typedef enum logic       {R_IDLE, R_DATA} rd_state_e;

  wr_state_e             wr_state_q, wr_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [IDX_W-1:0]      awidx_q, awidx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [31:0]           wr_idx;

  rd_state_e             rd_state_q, rd_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [31:0]           rd_idx;

  // Byte-offset bits of both addresses are deliberately ignored by the map.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi.s_axi_awaddr[1:0], s_axi.s_axi_araddr[1:0]};

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awidx_d    = awidx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;
    wr_idx     = 32'(awidx_q);
    case (wr_state_q)
      W_IDLE: begin
        if (s_axi.s_axi_awvalid && awready_q) begin
          aw_held_d = 1'b1;
          awidx_d   = s_axi.s_axi_awaddr[ADDR_WIDTH-1:2];
        end
        if (s_axi.s_axi_wvalid && wready_q) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi.s_axi_wdata;
          wstrb_d  = s_axi.s_axi_wstrb;
        end
        if (aw_held_d && w_held_d) wr_state_d = W_COMMIT;
      end
      W_COMMIT: begin
        bvalid_d   = 1'b1;
        bresp_d    = RESP_SLVERR;
        wr_state_d = W_RESP;
        if (wr_idx < NREG_U) begin
          bresp_d = RESP_OKAY;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == i[31:0]) begin
              wr_pulse_d[i] = 1'b1;
              for (int k = 0; k < STRB_W; k++) begin
                if (wstrb_q[k]) regs_d[i][8*k +: 8] = wdata_q[8*k +: 8];
              end
            end
          end
        end
      end
      W_RESP: begin
        if (s_axi.s_axi_bready) begin
          bvalid_d   = 1'b0;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
    // Readies are registered copies of "will we accept next cycle".
    awready_d = (wr_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (wr_state_d == W_IDLE) && !w_held_d;
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      wr_state_q <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awidx_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awidx_q    <= awidx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_idx     = 32'(s_axi.s_axi_araddr[ADDR_WIDTH-1:2]);
    case (rd_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (s_axi.s_axi_arvalid && arready_q) begin
          rd_state_d = R_DATA;
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rresp_d    = RESP_SLVERR;
          rdata_d    = DATA_WIDTH'(32'hDEADBEEF);
          // Sampling regs_q (not regs_d) makes a read racing a commit return the old value.
          if (rd_idx < NREG_U) begin
            rresp_d = RESP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) begin
              if (rd_idx == i[31:0]) rdata_d = regs_q[i];
            end
          end else if (rd_idx < NEND_U) begin
            rresp_d = RESP_OKAY;
            for (int j = 0; j < NUM_STATUS; j++) begin
              if (rd_idx == NREG_U + j[31:0]) rdata_d = status_in[j*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end
      R_DATA: begin
        if (s_axi.s_axi_rready) begin
          rd_state_d = R_IDLE;
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign ctrl_regs[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  assign wr_pulse            = wr_pulse_q;
  assign s_axi.s_axi_awready = awready_q;
  assign s_axi.s_axi_wready  = wready_q;
  assign s_axi.s_axi_bvalid  = bvalid_q;
  assign s_axi.s_axi_bresp   = bresp_q;
  assign s_axi.s_axi_arready = arready_q;
  assign s_axi.s_axi_rvalid  = rvalid_q;
  assign s_axi.s_axi_rdata   = rdata_q;
  assign s_axi.s_axi_rresp   = rresp_q;
  assign dbg_wr_state_o      = wr_state_q;
  assign dbg_rd_state_o      = rd_state_q;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Bench for axi_lite_regfile (8 control regs, 2 status words): directed cases plus random concurrent traffic,
// all outputs compared each cycle against a transaction-level model of the register map.
module tb_axi_lite_regfile;
  localparam int          DW      = 32;
  localparam int          AW      = 6;
  localparam int          NR      = 8;
  localparam int          NS      = 2;
  localparam logic [31:0] RST_VAL = 32'h5A5A_0F0F;

  logic            clk;
  logic            areset;
  logic [NR*DW-1:0] ctrl_regs;
  logic [NR-1:0]   wr_pulse;
  logic [NS*DW-1:0] status_in;
  logic [1:0]      dbg_wr_state;
  logic            dbg_rd_state;

  int total = 0;
  int bad   = 0;

  axi_lite_regfile_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  axi_lite_regfile #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .NUM_STATUS(NS), .RESET_VAL(RST_VAL)
  ) dut (
    .s_axi_aclk     (clk),
    .s_axi_areset   (areset),
    .s_axi          (bus.slave),
    .ctrl_regs      (ctrl_regs),
    .wr_pulse       (wr_pulse),
    .status_in      (status_in),
    .dbg_wr_state_o (dbg_wr_state),
    .dbg_rd_state_o (dbg_rd_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [NR];
  logic [5:0]  aw_q [$];
  logic [35:0] w_q [$];
  logic [33:0] exp_q [$];

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = m_regs[i];
    return f;
  endfunction

  function automatic logic [33:0] model_read(input logic [5:0] a);
    logic [3:0] idx;
    idx = a[5:2];
    if (idx < 4'd8) return {2'b00, m_regs[idx[2:0]]};
    if (idx == 4'd8) return {2'b00, status_in[31:0]};
    if (idx == 4'd9) return {2'b00, status_in[63:32]};
    return {2'b10, 32'hDEADBEEF};
  endfunction

  // Scoreboard: consumes handshakes seen on the bus, applies writes when their response appears.
  initial begin : monitor
    logic        rst_edge;
    logic        prev_rst;
    logic        prev_bvalid;
    logic [1:0]  exp_bresp;
    logic [7:0]  exp_pulse;
    logic [5:0]  a;
    logic [35:0] w;
    logic [3:0]  idx;
    prev_rst    = 1'b0;
    prev_bvalid = 1'b0;
    exp_bresp   = 2'b00;
    forever begin
      @(posedge clk);
      rst_edge = areset;
      @(negedge clk);
      if (rst_edge) begin
        aw_q.delete(); w_q.delete(); exp_q.delete();
        for (int i = 0; i < NR; i++) m_regs[i] = RST_VAL;
        check("rst_valids", {bus.s_axi_bvalid, bus.s_axi_rvalid, bus.s_axi_awready,
                             bus.s_axi_wready, bus.s_axi_arready}, 5'b0);
        check("rst_resp_data", {bus.s_axi_bresp, bus.s_axi_rresp, bus.s_axi_rdata}, '0);
        check("rst_pulse", wr_pulse, 8'h00);
        check("rst_regs", ctrl_regs, model_flat());
        prev_bvalid = 1'b0;
        prev_rst    = 1'b1;
        continue;
      end
      if (prev_rst)
        check("ready_after_rst", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 3'b111);
      prev_rst  = 1'b0;
      exp_pulse = 8'h00;
      if (bus.s_axi_bvalid && !prev_bvalid) begin
        if (aw_q.size() == 0 || w_q.size() == 0) begin
          check("stale_b", 1'b1, 1'b0);
        end else begin
          a = aw_q.pop_front();
          w = w_q.pop_front();
          idx = a[5:2];
          if (idx < 4'd8) begin
            exp_bresp = 2'b00;
            exp_pulse[idx[2:0]] = 1'b1;
            for (int k = 0; k < 4; k++)
              if (w[32+k]) m_regs[idx[2:0]][8*k +: 8] = w[8*k +: 8];
          end else begin
            exp_bresp = 2'b10;
          end
        end
      end
      if (bus.s_axi_bvalid) begin
        check("bresp", bus.s_axi_bresp, exp_bresp);
        check("aw_w_blocked", {bus.s_axi_awready, bus.s_axi_wready}, 2'b00);
      end
      check("wr_pulse", wr_pulse, exp_pulse);
      check("ctrl_regs", ctrl_regs, model_flat());
      if (bus.s_axi_rvalid) begin
        if (exp_q.size() == 0) begin
          check("stale_r", 1'b1, 1'b0);
        end else begin
          check("rdata_rresp", {bus.s_axi_rresp, bus.s_axi_rdata}, exp_q[0]);
          check("ar_blocked", bus.s_axi_arready, 1'b0);
          if (bus.s_axi_rready) void'(exp_q.pop_front());
        end
      end
      if (!areset) begin
        if (bus.s_axi_awvalid && bus.s_axi_awready) aw_q.push_back(bus.s_axi_awaddr);
        if (bus.s_axi_wvalid && bus.s_axi_wready) w_q.push_back({bus.s_axi_wstrb, bus.s_axi_wdata});
        if (bus.s_axi_arvalid && bus.s_axi_arready) exp_q.push_back(model_read(bus.s_axi_araddr));
      end
      prev_bvalid = bus.s_axi_bvalid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_aw(input logic [5:0] a, input int dly);
    logic ok;
    ok = 1'b0;
    repeat (dly) @(posedge clk);
    #1; bus.s_axi_awvalid = 1'b1; bus.s_axi_awaddr = a;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (bus.s_axi_awready) ok = 1'b1;
    end
    check("aw_accept", ok, 1'b1);
    @(posedge clk); #1; bus.s_axi_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    logic ok;
    ok = 1'b0;
    repeat (dly) @(posedge clk);
    #1; bus.s_axi_wvalid = 1'b1; bus.s_axi_wdata = d; bus.s_axi_wstrb = s;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (bus.s_axi_wready) ok = 1'b1;
    end
    check("w_accept", ok, 1'b1);
    @(posedge clk); #1; bus.s_axi_wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [5:0] a, input int dly);
    logic ok;
    ok = 1'b0;
    repeat (dly) @(posedge clk);
    #1; bus.s_axi_arvalid = 1'b1; bus.s_axi_araddr = a;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (bus.s_axi_arready) ok = 1'b1;
    end
    check("ar_accept", ok, 1'b1);
    @(posedge clk); #1; bus.s_axi_arvalid = 1'b0;
  endtask

  task automatic write_txn(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
    fork
      send_aw(a, aw_dly);
      send_w(d, s, w_dly);
    join
    @(negedge clk); check("b_lat_commit", bus.s_axi_bvalid, 1'b0);
    @(negedge clk); check("b_lat_resp", bus.s_axi_bvalid, 1'b1);
    resp = bus.s_axi_bresp;
    repeat (b_dly) @(negedge clk);
    @(posedge clk); #1; bus.s_axi_bready = 1'b1;
    @(posedge clk); #1; bus.s_axi_bready = 1'b0;
  endtask

  task automatic read_txn(input logic [5:0] a, input int ar_dly, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
    send_ar(a, ar_dly);
    @(negedge clk); check("r_lat", bus.s_axi_rvalid, 1'b1);
    data = bus.s_axi_rdata;
    resp = bus.s_axi_rresp;
    repeat (r_dly) @(negedge clk);
    @(posedge clk); #1; bus.s_axi_rready = 1'b1;
    @(posedge clk); #1; bus.s_axi_rready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [1:0]  resp;
    logic [31:0] data;
    logic        both_up;
    areset = 1'b1;
    status_in = '0;
    bus.s_axi_awvalid = 1'b0; bus.s_axi_awaddr = '0;
    bus.s_axi_wvalid  = 1'b0; bus.s_axi_wdata  = '0; bus.s_axi_wstrb = '0;
    bus.s_axi_bready  = 1'b0;
    bus.s_axi_arvalid = 1'b0; bus.s_axi_araddr = '0;
    bus.s_axi_rready  = 1'b0;
    repeat (3) @(posedge clk);
    #1; areset = 1'b0;
    @(negedge clk);
    check("reset_regs_literal", ctrl_regs, {8{RST_VAL}});

    // W arrives 3 cycles before AW
    write_txn(6'h04, 32'h1234_5678, 4'hF, 3, 0, 0, resp);
    check("wfirst_bresp", resp, 2'b00);
    check("reg1_full", ctrl_regs[63:32], 32'h1234_5678);

    write_txn(6'h04, 32'hAABB_CCDD, 4'b0101, 0, 0, 0, resp);
    check("reg1_partial", ctrl_regs[63:32], 32'h12BB_56DD);

    write_txn(6'h00, 32'hFFFF_FFFF, 4'h0, 0, 1, 0, resp);
    check("zero_strb_okay", resp, 2'b00);
    check("reg0_unchanged", ctrl_regs[31:0], RST_VAL);

    // B backpressure with a second AW waiting
    fork
      write_txn(6'h08, 32'h0BAD_F00D, 4'hF, 0, 0, 5, resp);
      begin
        logic [1:0] resp2;
        repeat (4) @(posedge clk);
        write_txn(6'h0C, 32'h600D_CAFE, 4'hF, 0, 0, 0, resp2);
        check("second_write_resp", resp2, 2'b00);
      end
      begin
        repeat (7) @(negedge clk);
        check("second_aw_blocked", {bus.s_axi_awvalid, bus.s_axi_awready, bus.s_axi_bvalid}, 3'b101);
      end
    join
    check("reg2_reg3", ctrl_regs[127:64], 64'h600D_CAFE_0BAD_F00D);

    // Status, unmapped and read-only-write cases
    #1; status_in = {32'h0000_0002, 32'hCAFE_0001};
    read_txn(6'h20, 0, 3, data, resp);
    check("status0_read", {resp, data}, {2'b00, 32'hCAFE_0001});
    read_txn(6'h3C, 0, 3, data, resp);
    check("unmapped_read", {resp, data}, {2'b10, 32'hDEADBEEF});
    write_txn(6'h20, 32'h1111_2222, 4'hF, 0, 0, 0, resp);
    check("status_write_slverr", resp, 2'b10);
    write_txn(6'h3D, 32'h1111_2222, 4'hF, 0, 0, 1, resp);
    check("unmapped_write_slverr", resp, 2'b10);

    // Random concurrent traffic
    fork
      begin
        logic [5:0] a;
        logic [1:0] r;
        for (int n = 0; n < 60; n++) begin
          a = ($urandom_range(0, 3) != 0) ? 6'($urandom_range(0, 39)) : 6'($urandom_range(40, 63));
          write_txn(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), r);
        end
      end
      begin
        logic [31:0] d;
        logic [1:0]  r;
        for (int n = 0; n < 60; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1; status_in = {$urandom, $urandom};
          end
          read_txn(6'($urandom_range(0, 63)), $urandom_range(0, 2), $urandom_range(0, 3), d, r);
        end
      end
    join

    // Reset while a B and an R are both pending
    fork
      send_aw(6'h00, 0);
      send_w(32'h7777_8888, 4'hF, 0);
      send_ar(6'h04, 0);
    join
    both_up = 1'b0;
    for (int n = 0; n < 10 && !both_up; n++) begin
      @(negedge clk);
      if (bus.s_axi_bvalid && bus.s_axi_rvalid) both_up = 1'b1;
    end
    check("mid_both_pending", both_up, 1'b1);
    @(posedge clk); #1; areset = 1'b1;
    @(posedge clk); #1; areset = 1'b0;
    @(negedge clk);
    check("mid_rst_valids", {bus.s_axi_bvalid, bus.s_axi_rvalid}, 2'b00);
    check("mid_rst_regs", ctrl_regs, {8{RST_VAL}});
    bus.s_axi_bready = 1'b1; bus.s_axi_rready = 1'b1;
    repeat (8) @(negedge clk);
    check("no_stale_after_rst", {bus.s_axi_bvalid, bus.s_axi_rvalid}, 2'b00);
    @(posedge clk); #1; bus.s_axi_bready = 1'b0; bus.s_axi_rready = 1'b0;

    write_txn(6'h1C, 32'hFEED_BEEF, 4'b1001, 0, 0, 0, resp);
    check("reg7_after_rst", ctrl_regs[255:224], 32'hFE5A_0FEF);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
